// File: rtl/ov_dvp_pattern_tx.sv
// ov_dvp_pattern_tx
// -----------------------------------------------------------------------------
// Stands in for an OV7670-style camera sensor. It drives the DVP pins
// (cam_vsync / href / 8-bit p_data) with complete RGB565 frames built from
// internal test patterns, one byte per clock, high byte first. The capture
// and memory path can then be exercised without a sensor attached.
//
// Frame layout, in line-times of LINE_CLKS = 2*FRAME_WIDTH + 2*H_BLANK clocks:
//   VSYNC_LINES   cam_vsync high
//   V_BACK_LINES  all low
//   FRAME_HEIGHT  active lines: 2*FRAME_WIDTH href bytes, then 2*H_BLANK low
//   V_FRONT_LINES all low; frame_count increments on the final clock
//
// Ports:
//   clk_i           byte clock, one p_data byte per cycle
//   reset_p_i       asynchronous, active-high reset
//   enable_i        start / continue frame generation (sampled between frames)
//   pattern_sel_i   0 colour bars, 1 coordinate, 2 checker, 3 solid white
//   cam_vsync_o     frame sync, active high
//   href_o          line valid, high during active bytes
//   p_data_o        RGB565 byte stream, high byte first
//   frame_count_o   completed frames, wraps 16'hFFFF -> 0
//   busy_o          high whenever the generator is not idle
//
// Optional build macro:
//   OV_TX_FRAME_TAG_EN  when defined, pixel (0,0) of each frame is replaced by
//                       {8'hA5, frame_count[7:0]} using the count at frame start.
// -----------------------------------------------------------------------------
module ov_dvp_pattern_tx #(
  parameter int FRAME_WIDTH   = 640,
  parameter int FRAME_HEIGHT  = 480,
  parameter int H_BLANK       = 144,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10
) (
  input  logic        clk_i,
  input  logic        reset_p_i,
  input  logic        enable_i,
  input  logic [1:0]  pattern_sel_i,
  output logic        cam_vsync_o,
  output logic        href_o,
  output logic [7:0]  p_data_o,
  output logic [15:0] frame_count_o,
  output logic        busy_o
);

  localparam int LINE_CLKS   = 2 * FRAME_WIDTH + 2 * H_BLANK;
  localparam int ACTIVE_CLKS = 2 * FRAME_WIDTH;
  localparam int BAR_PIX     = FRAME_WIDTH / 8;

  localparam int MAX_A     = (VSYNC_LINES > V_BACK_LINES) ? VSYNC_LINES : V_BACK_LINES;
  localparam int MAX_B     = (FRAME_HEIGHT > V_FRONT_LINES) ? FRAME_HEIGHT : V_FRONT_LINES;
  localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  localparam int CLK_W  = $clog2(LINE_CLKS);
  localparam int LINE_W = $clog2(MAX_LINES + 1);
  localparam int BAR_W  = $clog2(BAR_PIX + 1);

  localparam logic [CLK_W-1:0]  LAST_CLK    = CLK_W'(LINE_CLKS - 1);
  localparam logic [CLK_W-1:0]  LAST_ACTIVE = CLK_W'(ACTIVE_CLKS - 1);
  localparam logic [LINE_W-1:0] VS_LAST     = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VB_LAST     = LINE_W'(V_BACK_LINES - 1);
  localparam logic [LINE_W-1:0] Y_LAST      = LINE_W'(FRAME_HEIGHT - 1);
  localparam logic [LINE_W-1:0] VF_LAST     = LINE_W'(V_FRONT_LINES - 1);
  localparam logic [BAR_W-1:0]  BAR_LAST    = BAR_W'(BAR_PIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    V_BACK,
    ACTIVE,
    HBLANK,
    V_FRONT
  } state_t;

  state_t             state_q, state_d;
  logic [CLK_W-1:0]   clkCnt_q, clkCnt_d;
  logic [LINE_W-1:0]  lineCnt_q, lineCnt_d;
  logic [1:0]         patSel_q, patSel_d;
  logic [15:0]        frameCount_q, frameCount_d;
  logic [2:0]         barIdx_q, barIdx_d;
  logic [BAR_W-1:0]   barPix_q, barPix_d;
  logic               camVsync_q, camVsync_d;
  logic               href_q, href_d;
  logic [7:0]         pData_q, pData_d;
  logic               busy_q, busy_d;
  logic               frameStart;
  logic               lineDone;
  logic [7:0]         xCoord;
  logic [7:0]         yCoord;
  logic [15:0]        pixel;

`ifdef OV_TX_FRAME_TAG_EN
  logic [7:0]         tag_q, tag_d;
`endif

  function automatic logic [15:0] barColour(input logic [2:0] idx);
    case (idx)
      3'd0:    barColour = 16'hFFFF;
      3'd1:    barColour = 16'hFFE0;
      3'd2:    barColour = 16'h07FF;
      3'd3:    barColour = 16'h07E0;
      3'd4:    barColour = 16'hF81F;
      3'd5:    barColour = 16'hF800;
      3'd6:    barColour = 16'h001F;
      default: barColour = 16'h0000;
    endcase
  endfunction

  // Frame sequencer. clkCnt runs across a whole line-time (active bytes then
  // horizontal blanking share one count), lineCnt counts line-times inside
  // each vertical phase and doubles as y during the active region.
  // enable and pattern_sel are only looked at on frame boundaries.
  always_comb begin
    state_d      = state_q;
    clkCnt_d     = clkCnt_q;
    lineCnt_d    = lineCnt_q;
    patSel_d     = patSel_q;
    frameCount_d = frameCount_q;
    frameStart   = 1'b0;
    lineDone     = (clkCnt_q == LAST_CLK);

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d    = VSYNC;
          clkCnt_d   = '0;
          lineCnt_d  = '0;
          frameStart = 1'b1;
        end
      end
      VSYNC: begin
        clkCnt_d = clkCnt_q + 1'b1;
        if (lineDone) begin
          clkCnt_d = '0;
          if (lineCnt_q == VS_LAST) begin
            lineCnt_d = '0;
            state_d   = V_BACK;
          end else begin
            lineCnt_d = lineCnt_q + 1'b1;
          end
        end
      end
      V_BACK: begin
        clkCnt_d = clkCnt_q + 1'b1;
        if (lineDone) begin
          clkCnt_d = '0;
          if (lineCnt_q == VB_LAST) begin
            lineCnt_d = '0;
            state_d   = ACTIVE;
          end else begin
            lineCnt_d = lineCnt_q + 1'b1;
          end
        end
      end
      ACTIVE: begin
        clkCnt_d = clkCnt_q + 1'b1;
        if (clkCnt_q == LAST_ACTIVE) begin
          state_d = HBLANK;
        end
      end
      HBLANK: begin
        clkCnt_d = clkCnt_q + 1'b1;
        if (lineDone) begin
          clkCnt_d = '0;
          if (lineCnt_q == Y_LAST) begin
            lineCnt_d = '0;
            state_d   = V_FRONT;
          end else begin
            lineCnt_d = lineCnt_q + 1'b1;
            state_d   = ACTIVE;
          end
        end
      end
      V_FRONT: begin
        clkCnt_d = clkCnt_q + 1'b1;
        if (lineDone) begin
          clkCnt_d = '0;
          if (lineCnt_q == VF_LAST) begin
            lineCnt_d    = '0;
            frameCount_d = frameCount_q + 16'd1;
            if (enable_i) begin
              state_d    = VSYNC;
              frameStart = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            lineCnt_d = lineCnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        clkCnt_d  = '0;
        lineCnt_d = '0;
      end
    endcase

    if (frameStart) begin
      patSel_d = pattern_sel_i;
    end
  end

  // Pixel generation. Outputs are registered, so everything here is computed
  // from the next-state counters: the byte that appears after an edge belongs
  // to the position the sequencer moves to on that edge. The colour-bar index
  // is tracked with a small counter instead of dividing x by the bar width.
  always_comb begin
    barIdx_d = barIdx_q;
    barPix_d = barPix_q;
    xCoord   = 8'(clkCnt_d >> 1);
    yCoord   = 8'(lineCnt_d);

    if (state_d == ACTIVE) begin
      if (clkCnt_d == '0) begin
        barIdx_d = '0;
        barPix_d = '0;
      end else if (!clkCnt_d[0]) begin
        if (barPix_q == BAR_LAST) begin
          barPix_d = '0;
          barIdx_d = barIdx_q + 3'd1;
        end else begin
          barPix_d = barPix_q + 1'b1;
        end
      end
    end

    case (patSel_q)
      2'd0:    pixel = barColour(barIdx_d);
      2'd1:    pixel = {yCoord, xCoord};
      2'd2:    pixel = (xCoord[4] ^ yCoord[4]) ? 16'hFFFF : 16'h0000;
      default: pixel = 16'hFFFF;
    endcase

`ifdef OV_TX_FRAME_TAG_EN
    tag_d = frameStart ? frameCount_d[7:0] : tag_q;
    if ((lineCnt_d == '0) && (clkCnt_d[CLK_W-1:1] == '0)) begin
      pixel = {8'hA5, tag_q};
    end
`endif

    camVsync_d = (state_d == VSYNC);
    href_d     = (state_d == ACTIVE);
    busy_d     = (state_d != IDLE);
    pData_d    = href_d ? (clkCnt_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
  end

  // State, counters and registered pin drivers. Reset is asynchronous so the
  // pins drop the instant reset_p_i rises, even mid-line.
  always_ff @(posedge clk_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      state_q      <= IDLE;
      clkCnt_q     <= '0;
      lineCnt_q    <= '0;
      patSel_q     <= '0;
      frameCount_q <= '0;
      barIdx_q     <= '0;
      barPix_q     <= '0;
      camVsync_q   <= 1'b0;
      href_q       <= 1'b0;
      pData_q      <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clkCnt_q     <= clkCnt_d;
      lineCnt_q    <= lineCnt_d;
      patSel_q     <= patSel_d;
      frameCount_q <= frameCount_d;
      barIdx_q     <= barIdx_d;
      barPix_q     <= barPix_d;
      camVsync_q   <= camVsync_d;
      href_q       <= href_d;
      pData_q      <= pData_d;
      busy_q       <= busy_d;
    end
  end

`ifdef OV_TX_FRAME_TAG_EN
  // Frame tag captured as each frame starts.
  always_ff @(posedge clk_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end
`endif

  assign cam_vsync_o   = camVsync_q;
  assign href_o        = href_q;
  assign p_data_o      = pData_q;
  assign frame_count_o = frameCount_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_ov_dvp_pattern_tx.sv
// tb_ov_dvp_pattern_tx
// Drives ov_dvp_pattern_tx with small frame parameters and compares every
// output, every cycle, against a model that knows only the frame position
// (a single counter over the whole frame) and the pattern formulas.
module tb_ov_dvp_pattern_tx;

  localparam int FW  = 8;
  localparam int FH  = 4;
  localparam int HB  = 2;
  localparam int VS  = 1;
  localparam int VB  = 1;
  localparam int VF  = 1;
  localparam int LINE_CLKS = 2 * FW + 2 * HB;
  localparam int FRAME_LEN = (VS + VB + FH + VF) * LINE_CLKS;

  logic        clk = 1'b0;
  logic        resetP;
  logic        enable;
  logic [1:0]  patternSel;
  logic        camVsync;
  logic        href;
  logic [7:0]  pData;
  logic [15:0] frameCount;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: running flag, position in frame, frame counter,
  // pattern and tag latched at frame start.
  bit       mRun = 1'b0;
  int       mPos = 0;
  int       mFc  = 0;
  int       mPat = 0;
  int       mTag = 0;

  ov_dvp_pattern_tx #(
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH),
    .H_BLANK      (HB),
    .VSYNC_LINES  (VS),
    .V_BACK_LINES (VB),
    .V_FRONT_LINES(VF)
  ) dut (
    .clk_i        (clk),
    .reset_p_i    (resetP),
    .enable_i     (enable),
    .pattern_sel_i(patternSel),
    .cam_vsync_o  (camVsync),
    .href_o       (href),
    .p_data_o     (pData),
    .frame_count_o(frameCount),
    .busy_o       (busy)
  );

  // Free-running byte clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: actual=%0h required=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [15:0] refPixel(input int pat, input int x, input int y);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = 8'(x);
    yb = 8'(y);
    case (pat)
      0: begin
        case (x / (FW / 8))
          0:       refPixel = 16'hFFFF;
          1:       refPixel = 16'hFFE0;
          2:       refPixel = 16'h07FF;
          3:       refPixel = 16'h07E0;
          4:       refPixel = 16'hF81F;
          5:       refPixel = 16'hF800;
          6:       refPixel = 16'h001F;
          default: refPixel = 16'h0000;
        endcase
      end
      1:       refPixel = {yb, xb};
      2:       refPixel = (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 16'hFFFF : 16'h0000;
      default: refPixel = 16'hFFFF;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic modelStep();
    if (!mRun) begin
      if (enable) begin
        mRun = 1'b1;
        mPos = 0;
        mPat = int'(patternSel);
        mTag = mFc;
      end
    end else if (mPos == FRAME_LEN - 1) begin
      mFc = (mFc + 1) & 16'hFFFF;
      if (enable) begin
        mPos = 0;
        mPat = int'(patternSel);
        mTag = mFc;
      end else begin
        mRun = 1'b0;
        mPos = 0;
      end
    end else begin
      mPos++;
    end
  endtask

  // Derive every expected pin value from the frame position alone.
  task automatic compareAll();
    int line;
    int c;
    int x;
    int y;
    logic        expVs;
    logic        expHref;
    logic [7:0]  expData;
    logic [15:0] pix;
    line    = mPos / LINE_CLKS;
    c       = mPos % LINE_CLKS;
    expVs   = mRun && (line < VS);
    expHref = mRun && (line >= VS + VB) && (line < VS + VB + FH) && (c < 2 * FW);
    expData = 8'h00;
    if (expHref) begin
      x   = c / 2;
      y   = line - VS - VB;
      pix = refPixel(mPat, x, y);
`ifdef OV_TX_FRAME_TAG_EN
      if (x == 0 && y == 0) pix = {8'hA5, 8'(mTag)};
`endif
      expData = (c % 2 == 0) ? pix[15:8] : pix[7:0];
    end
    checkOutput("vsync",  32'(camVsync),   32'(expVs));
    checkOutput("href",   32'(href),       32'(expHref));
    checkOutput("pdata",  32'(pData),      32'(expData));
    checkOutput("fcount", 32'(frameCount), 32'(mFc));
    checkOutput("busy",   32'(busy),       32'(mRun));
  endtask

  // Hold the inputs for n clocks, checking all outputs after each edge.
  task automatic applyStimulus(input logic en, input logic [1:0] pat, input int n);
    enable     = en;
    patternSel = pat;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      compareAll();
    end
  endtask

  initial begin
    resetP     = 1'b1;
    enable     = 1'b0;
    patternSel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_vsync",  32'(camVsync),   32'd0);
    checkOutput("rst_href",   32'(href),       32'd0);
    checkOutput("rst_pdata",  32'(pData),      32'd0);
    checkOutput("rst_fcount", 32'(frameCount), 32'd0);
    checkOutput("rst_busy",   32'(busy),       32'd0);
    resetP = 1'b0;

    applyStimulus(1'b0, 2'd0, 5);

    // Coordinate pattern, single frame, enable dropped during vsync.
    applyStimulus(1'b1, 2'd1, 10);
    applyStimulus(1'b0, 2'd2, 150);

    // Colour bars, single frame.
    applyStimulus(1'b1, 2'd0, 1);
    applyStimulus(1'b0, 2'd3, 150);

    // Three back-to-back frames; pattern changes mid-run are ignored.
    applyStimulus(1'b1, 2'd2, FRAME_LEN);
    applyStimulus(1'b1, 2'd1, FRAME_LEN);
    applyStimulus(1'b1, 2'd0, FRAME_LEN - 5);
    applyStimulus(1'b0, 2'd3, 20);

    // Enable dropped during active line 1.
    applyStimulus(1'b1, 2'd1, 65);
    applyStimulus(1'b0, 2'd0, 100);

    // Random enable / pattern phases.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'(($urandom % 4) != 0), 2'($urandom_range(0, 3)), int'($urandom_range(1, 180)));
    end
    applyStimulus(1'b0, 2'd0, FRAME_LEN + 5);

    // Reset asserted mid-line while href is high.
    applyStimulus(1'b1, 2'd2, 45);
    #2 resetP = 1'b1;
    #1;
    checkOutput("mid_rst_href",   32'(href),       32'd0);
    checkOutput("mid_rst_pdata",  32'(pData),      32'd0);
    checkOutput("mid_rst_fcount", 32'(frameCount), 32'd0);
    checkOutput("mid_rst_busy",   32'(busy),       32'd0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetP = 1'b0;
    mRun   = 1'b0;
    mPos   = 0;
    mFc    = 0;

    // Full frame after reset release, then a second one to check its length.
    applyStimulus(1'b1, 2'd3, FRAME_LEN);
    applyStimulus(1'b0, 2'd1, FRAME_LEN + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
